// File: rtl/alu4_issue_queue.sv
// alu4_issue_queue
//   Command queue and result register placed directly in front of the
//   combinational ALU4. Commands {A, b, option} are buffered in a FIFO. The
//   queue head drives ALU4's inputs. ALU4's result and flags are captured into
//   a registered output slot. Commands and results stay in order.
//
// Parameters
//   DEPTH         FIFO entries (power of 2, >= 2). Data width is fixed at 4 bits.
//
// Ports
//   clk, rst_n                  rising-edge clock, async active-low reset
//   in_valid/in_ready           command handshake
//   in_a, in_b, in_op           command payload (4b, 4b, 3b option code)
//   alu_a, alu_b, alu_option    queue head to ALU4 (zeros when empty)
//   alu_result, alu_carry,
//   alu_overflow, alu_zero      ALU4 outputs, captured at issue
//   out_valid/out_ready         result handshake
//   out_result, out_carry,
//   out_overflow, out_zero      registered result slot
//   issued_cnt                  8-bit count of issues, wraps 255->0
//
// Optional feature (macro ALU4_STICKY_FLAGS_EN)
//   Adds input clr_sticky and output sticky_ovf. sticky_ovf is a sticky
//   overflow flag. It is set on any issue that sees alu_overflow=1, and it is
//   cleared by clr_sticky. When both happen in the same cycle, the set wins.
//
// Handshake semantics (both sides): a transfer happens at a rising edge where
// valid & ready are both high. The sender holds valid and the payload stable
// until that edge. ready never depends on valid.
module alu4_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [2:0] in_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_option,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_result,
  output logic       out_carry,
  output logic       out_overflow,
  output logic       out_zero,
  output logic [7:0] issued_cnt
`ifdef ALU4_STICKY_FLAGS_EN
  ,
  input  logic       clr_sticky,
  output logic       sticky_ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  slot_state_e   slot_state_q;
  logic [3:0]    out_result_q;
  logic          out_carry_q, out_overflow_q, out_zero_q;
  logic [7:0]    issued_cnt_q;
  logic [10:0]   head;
  logic          not_empty;
  logic          push;
  logic          issue;

  assign not_empty = (count_q != '0);
  // in_ready looks only at the count. A pop in the same cycle does not free a
  // full queue until the next cycle.
  assign in_ready  = (count_q != FULL_CNT);
  assign push      = in_valid & in_ready;
  assign out_valid = (slot_state_q == SLOT_FULL);
  // The slot can take a new result when it is empty or is being drained now.
  assign issue     = not_empty & (~out_valid | out_ready);

  assign head       = mem_q[rd_ptr_q];
  assign alu_a      = not_empty ? head[10:7] : 4'h0;
  assign alu_b      = not_empty ? head[6:3]  : 4'h0;
  assign alu_option = not_empty ? head[2:0]  : 3'b000;

  assign out_result   = out_result_q;
  assign out_carry    = out_carry_q;
  assign out_overflow = out_overflow_q;
  assign out_zero     = out_zero_q;
  assign issued_cnt   = issued_cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (issue) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset. An entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b, in_op};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Output slot FSM. out_* are written only on an issue, so they hold their
  // value while the slot waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_state_q   <= SLOT_EMPTY;
      out_result_q   <= 4'h0;
      out_carry_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      issued_cnt_q   <= 8'h00;
    end else begin
      if (issue) begin
        slot_state_q   <= SLOT_FULL;
        out_result_q   <= alu_result;
        out_carry_q    <= alu_carry;
        out_overflow_q <= alu_overflow;
        out_zero_q     <= alu_zero;
        issued_cnt_q   <= issued_cnt_q + 8'h01;
      end else if (out_ready) begin
        slot_state_q <= SLOT_EMPTY;
      end
    end
  end

`ifdef ALU4_STICKY_FLAGS_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (issue & alu_overflow) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_ovf = sticky_q;
`endif

endmodule
